// File: rtl/modulo_barrett_pipe.sv
`default_nettype none
// ============================================================================
// Module   : modulo_barrett_pipe
// Brief    : Three-stage, back-pressurable Barrett reducer computing
//            in_data_i mod MODULUS for a constant modulus, with a sideband
//            user field carried alongside each beat.
//            Optional macro MODULO_BARRETT_PIPE_CHECK_EN adds a shadow
//            pipeline using the native '%' operator and a sticky err_o.
// Revision : 1.0 - initial release
// ============================================================================
module modulo_barrett_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int MODULUS    = 7,
    parameter int USER_WIDTH = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_WIDTH-1:0]      in_data_i,
    input  logic [USER_WIDTH-1:0]      in_user_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [$clog2(MODULUS)-1:0] out_data_o,
    output logic [USER_WIDTH-1:0]      out_user_o,
    output logic                       err_o
);

    localparam int R_WIDTH = $clog2(MODULUS);

    // Constants sized to the arithmetic they feed, so no implicit widening
    localparam logic [DATA_WIDTH:0] c_TWO_POW = {1'b1, {DATA_WIDTH{1'b0}}};
    localparam logic [DATA_WIDTH:0] c_MOD_W   = (DATA_WIDTH+1)'(MODULUS);
    localparam logic [R_WIDTH:0]    c_MOD_R   = (R_WIDTH+1)'(MODULUS);
    localparam logic [DATA_WIDTH:0] M         = c_TWO_POW / c_MOD_W;

    // Reject illegal configurations at elaboration
    generate
        if (DATA_WIDTH < 2) begin : g_bad_data_width
            $error("modulo_barrett_pipe: DATA_WIDTH must be >= 2");
        end
        if (MODULUS < 2) begin : g_bad_modulus_low
            $error("modulo_barrett_pipe: MODULUS must be >= 2");
        end
        if ((DATA_WIDTH < 31) && (MODULUS >= (1 << DATA_WIDTH))) begin : g_bad_modulus_high
            $error("modulo_barrett_pipe: MODULUS must be < 2**DATA_WIDTH");
        end
        if (USER_WIDTH < 1) begin : g_bad_user_width
            $error("modulo_barrett_pipe: USER_WIDTH must be >= 1");
        end
    endgenerate

    // Stage registers
    logic                    r_s1_valid;
    logic [DATA_WIDTH-1:0]   r_s1_x;
    logic [2*DATA_WIDTH:0]   r_s1_p;
    logic [USER_WIDTH-1:0]   r_s1_user;

    logic                    r_s2_valid;
    logic [R_WIDTH:0]        r_s2_r;
    logic [USER_WIDTH-1:0]   r_s2_user;

    logic                    r_s3_valid;
    logic [R_WIDTH-1:0]      r_s3_data;
    logic [USER_WIDTH-1:0]   r_s3_user;

    // Combinational datapath
    logic                    w_adv;
    logic                    w_accept;
    logic [2*DATA_WIDTH:0]   w_p;
    logic [DATA_WIDTH:0]     w_q;
    logic [DATA_WIDTH:0]     w_qm;
    logic [DATA_WIDTH:0]     w_r_full;
    logic [R_WIDTH:0]        w_corr;
    logic                    w_unused_bits;

    // The whole pipe moves as one: it advances whenever the output slot frees
    assign w_adv      = !r_s3_valid || out_ready_i;
    assign w_accept   = in_valid_i && w_adv;
    assign in_ready_o = w_adv;

    // Full-width product; the low half is only the fractional part of x*M/2^W
    assign w_p = {{(DATA_WIDTH+1){1'b0}}, in_data_i} * {{DATA_WIDTH{1'b0}}, M};

    // q underestimates floor(x/MODULUS) by at most one, so q*MODULUS <= x
    // and the subtraction cannot wrap; the remainder fits in R_WIDTH+1 bits
    assign w_q      = r_s1_p[2*DATA_WIDTH:DATA_WIDTH];
    assign w_qm     = w_q * c_MOD_W;
    assign w_r_full = {1'b0, r_s1_x} - w_qm;

    // Single conditional subtract brings r from [0, 2*MODULUS) into range
    assign w_corr = (r_s2_r >= c_MOD_R) ? (r_s2_r - c_MOD_R) : r_s2_r;

    // Bits that are dropped by construction (fraction, always-zero MSBs)
    assign w_unused_bits = ^{r_s1_p[DATA_WIDTH-1:0], w_r_full, w_corr[R_WIDTH]};

    // Stage 1: capture the dividend and its product with the Barrett factor
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_p     <= '0;
            r_s1_user  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_x    <= in_data_i;
                r_s1_p    <= w_p;
                r_s1_user <= in_user_i;
            end
        end
    end

    // Stage 2: quotient estimate and partial remainder
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_s2_r     <= '0;
            r_s2_user  <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_r     <= w_r_full[R_WIDTH:0];
            r_s2_user  <= r_s1_user;
        end
    end

    // Stage 3: final correction, held stable while downstream stalls
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s3_valid <= 1'b0;
            r_s3_data  <= '0;
            r_s3_user  <= '0;
        end else if (w_adv) begin
            r_s3_valid <= r_s2_valid;
            r_s3_data  <= w_corr[R_WIDTH-1:0];
            r_s3_user  <= r_s2_user;
        end
    end

    assign out_valid_o = r_s3_valid;
    assign out_data_o  = r_s3_data;
    assign out_user_o  = r_s3_user;

`ifdef MODULO_BARRETT_PIPE_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] c_MOD_X = DATA_WIDTH'(MODULUS);

    logic [DATA_WIDTH-1:0] w_ref_full;
    logic                  w_unused_ref;
    logic [R_WIDTH-1:0]    r_s1_ref;
    logic [R_WIDTH-1:0]    r_s2_ref;
    logic [R_WIDTH-1:0]    r_s3_ref;
    logic                  r_err;

    assign w_ref_full   = in_data_i % c_MOD_X;
    assign w_unused_ref = ^w_ref_full;

    // Shadow pipeline: native remainder travelling in lockstep with the beat
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s1_ref <= '0;
            r_s2_ref <= '0;
            r_s3_ref <= '0;
        end else if (w_adv) begin
            if (w_accept) begin
                r_s1_ref <= w_ref_full[R_WIDTH-1:0];
            end
            r_s2_ref <= r_s1_ref;
            r_s3_ref <= r_s2_ref;
        end
    end

    // Sticky mismatch flag, evaluated as each valid result leaves
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (r_s3_valid && w_adv && (r_s3_data != r_s3_ref)) begin
            r_err <= 1'b1;
            $error("modulo_barrett_pipe: Barrett result %0d != reference %0d",
                   r_s3_data, r_s3_ref);
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_modulo_barrett_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_modulo_barrett_pipe
// Brief    : Self-checking bench for modulo_barrett_pipe. A DATA_WIDTH=8,
//            MODULUS=7 instance covers reset, latency, streaming,
//            backpressure and mid-stream reset; four DATA_WIDTH=16 instances
//            (MODULUS 2, 3, 1000, 65535) cover the modulus sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modulo_barrett_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- main instance (8-bit, mod 7) ----------------
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_user;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_data;
    logic [3:0] out_user;
    logic       err;

    modulo_barrett_pipe #(.DATA_WIDTH(8), .MODULUS(7), .USER_WIDTH(4)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_user_i   (in_user),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_user_o  (out_user),
        .err_o       (err)
    );

    // ---------------- sweep instances (16-bit) ----------------
    logic [15:0] sw_x;
    logic        sw_valid;
    logic        sw_tag;
    logic [3:0]  sw_irdy;
    logic [3:0]  sw_ovld;
    logic [3:0]  sw_user;
    logic [3:0]  sw_err;
    logic [0:0]  sw_d0;
    logic [1:0]  sw_d1;
    logic [9:0]  sw_d2;
    logic [15:0] sw_d3;

    modulo_barrett_pipe #(.DATA_WIDTH(16), .MODULUS(2), .USER_WIDTH(1)) u_sw0 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(sw_valid), .in_ready_o(sw_irdy[0]),
        .in_data_i(sw_x), .in_user_i(sw_tag), .out_valid_o(sw_ovld[0]), .out_ready_i(1'b1),
        .out_data_o(sw_d0), .out_user_o(sw_user[0]), .err_o(sw_err[0]));
    modulo_barrett_pipe #(.DATA_WIDTH(16), .MODULUS(3), .USER_WIDTH(1)) u_sw1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(sw_valid), .in_ready_o(sw_irdy[1]),
        .in_data_i(sw_x), .in_user_i(sw_tag), .out_valid_o(sw_ovld[1]), .out_ready_i(1'b1),
        .out_data_o(sw_d1), .out_user_o(sw_user[1]), .err_o(sw_err[1]));
    modulo_barrett_pipe #(.DATA_WIDTH(16), .MODULUS(1000), .USER_WIDTH(1)) u_sw2 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(sw_valid), .in_ready_o(sw_irdy[2]),
        .in_data_i(sw_x), .in_user_i(sw_tag), .out_valid_o(sw_ovld[2]), .out_ready_i(1'b1),
        .out_data_o(sw_d2), .out_user_o(sw_user[2]), .err_o(sw_err[2]));
    modulo_barrett_pipe #(.DATA_WIDTH(16), .MODULUS(65535), .USER_WIDTH(1)) u_sw3 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(sw_valid), .in_ready_o(sw_irdy[3]),
        .in_data_i(sw_x), .in_user_i(sw_tag), .out_valid_o(sw_ovld[3]), .out_ready_i(1'b1),
        .out_data_o(sw_d3), .out_user_o(sw_user[3]), .err_o(sw_err[3]));

    // ---------------- reference model: ordered queue of accepted beats ----------------
    typedef struct packed {
        logic [3:0] user;
        logic [7:0] x;
    } beat_t;

    beat_t      mq[$];
    int         n_drained = 0;
    logic       hold_pend = 1'b0;
    logic [2:0] hold_d;
    logic [3:0] hold_u;

    // Main scoreboard: a reset empties the model; every drained beat must be
    // the oldest outstanding one, reduced mod 7; stalled outputs must not move
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            mq.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", out_data, hold_d);
                check("stall_user_held", out_user, hold_u);
            end
            hold_pend = 1'b0;
            if (out_valid && out_ready) begin
                if (mq.size() == 0) begin
                    check("spurious_output", 1, 0);
                end else begin
                    e = mq.pop_front();
                    check("sb_data", out_data, e.x % 8'd7);
                    check("sb_user", out_user, e.user);
                end
                n_drained++;
            end else if (out_valid) begin
                hold_pend = 1'b1;
                hold_d    = out_data;
                hold_u    = out_user;
            end
            if (in_valid && in_ready) begin
                e.x    = in_data;
                e.user = in_user;
                mq.push_back(e);
            end
        end
    end

    // Sweep scoreboard: all four instances see the same beats and never stall
    logic [16:0] sq[$];
    always @(negedge clk) begin
        logic [16:0]  e;
        int unsigned  xv;
        if (!rst_n) begin
            sq.delete();
        end else begin
            if (sw_ovld[0]) begin
                if (sq.size() == 0) begin
                    check("sweep_spurious", 1, 0);
                end else begin
                    e  = sq.pop_front();
                    xv = 32'(e[15:0]);
                    check("sweep_valid_align", sw_ovld, 4'hF);
                    check("sweep_m2", sw_d0, xv % 2);
                    check("sweep_m3", sw_d1, xv % 3);
                    check("sweep_m1000", sw_d2, xv % 1000);
                    check("sweep_m65535", sw_d3, xv % 65535);
                    check("sweep_user", sw_user, {4{e[16]}});
                end
            end
            if (sw_valid && sw_irdy[0]) sq.push_back({sw_tag, sw_x});
        end
    end

    // One isolated beat: result must be presented so that it is consumed at
    // the third edge after the accepting edge, with matching data and user
    task automatic run_directed(input string name, input logic [7:0] x,
                                input logic [3:0] u, input logic [2:0] exp_d);
        int  n;
        bit  seen;
        in_data  = x;
        in_user  = u;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        n    = 0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                n    = k;
                check({name, "_data"}, out_data, exp_d);
                check({name, "_user"}, out_user, u);
            end
        end
        check({name, "_latency"}, n, 3);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0] x;
        logic [3:0] u;
        logic [2:0] exp_d;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int d0;

        tbl[0] = '{8'd255, 4'h1, 3'd3};
        tbl[1] = '{8'd7,   4'h2, 3'd0};
        tbl[2] = '{8'd6,   4'h3, 3'd6};
        tbl[3] = '{8'd0,   4'h4, 3'd0};
        tbl[4] = '{8'd200, 4'h5, 3'd4};
        tbl[5] = '{8'd13,  4'hF, 3'd6};

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd50;
        in_user   = 4'h9;
        out_ready = 1'b1;
        sw_valid  = 1'b0;
        sw_x      = '0;
        sw_tag    = 1'b0;

        // Reset with a valid input present: nothing captured, outputs clear
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_user", out_user, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sweep_valid", sw_ovld, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("post_rst_idle", out_valid, 0);
        end
        @(negedge clk);
        check("post_rst_first_valid", out_valid, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Table-driven isolated beats, including the correction path
        for (int i = 0; i < 6; i++) begin
            run_directed($sformatf("vec%0d", i), tbl[i].x, tbl[i].u, tbl[i].exp_d);
        end

        // Back-to-back stream 0..255 at full throughput
        d0 = n_drained;
        for (int x = 0; x < 256; x++) begin
            in_valid = 1'b1;
            in_data  = 8'(x);
            in_user  = 4'(x);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stream_count", n_drained - d0, 256);
        check("stream_idle_after", out_valid, 0);
        check("stream_err", err, 0);

        // Random valid and random downstream ready
        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            in_user   = 4'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("bp_all_drained", mq.size(), 0);

        // Three beats in flight, then reset: none may emerge afterwards
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(20 + i);
            in_user  = 4'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_valid_cleared", out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        run_directed("post_midrst", 8'd100, 4'hA, 3'd2);

        // Modulus sweep on the 16-bit instances: corners then random values
        begin
            int unsigned mods[4];
            mods[0] = 2; mods[1] = 3; mods[2] = 1000; mods[3] = 65535;
            for (int m = 0; m < 4; m++) begin
                for (int c = 0; c < 4; c++) begin
                    sw_valid = 1'b1;
                    sw_tag   = 1'(c);
                    case (c)
                        0:       sw_x = 16'd0;
                        1:       sw_x = 16'(mods[m] - 1);
                        2:       sw_x = 16'(mods[m]);
                        default: sw_x = 16'hFFFF;
                    endcase
                    @(posedge clk); #1;
                end
            end
        end
        for (int c = 0; c < 10000; c++) begin
            sw_valid = 1'b1;
            sw_x     = 16'($urandom);
            sw_tag   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        sw_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("sweep_all_drained", sq.size(), 0);
        check("sweep_err", sw_err, 0);
        check("final_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modulo_barrett_pipe.md
# modulo_barrett_pipe

Pipelined, back-pressurable Barrett modulo reducer. It computes `data_i mod MODULUS` for a compile-time constant modulus in three registered stages, using a valid/ready handshake on both sides. A sideband user field travels alongside each result. It is the streaming successor to the combinational `modulo_barrett` and replaces it wherever the reducer sits on a datapath with flow control, such as bank/lane index generation and hash bucketing.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: dividend width; must be ≥ 2.
- `MODULUS`, default 7: constant divisor; must be ≥ 2 and < 2^DATA_WIDTH. Elaboration fails otherwise.
- `USER_WIDTH`, default 1: sideband width; must be ≥ 1. The sideband passes through unmodified.
- `R_WIDTH` (localparam) = `$clog2(MODULUS)`.
- `M` (localparam) = floor(2^DATA_WIDTH / MODULUS), held in DATA_WIDTH+1 bits.

Ports:
- `clk_i`, in, 1: clock; all logic on the rising edge.
- `rst_ni`, in, 1: reset. **Synchronous, active-low.**
- `in_valid_i`, in, 1: input beat valid.
- `in_ready_o`, out, 1: block accepts a beat this cycle.
- `in_data_i`, in, DATA_WIDTH: dividend x.
- `in_user_i`, in, USER_WIDTH: sideband.
- `out_valid_o`, out, 1: result valid.
- `out_ready_i`, in, 1: downstream accepts.
- `out_data_o`, out, R_WIDTH: x mod MODULUS.
- `out_user_o`, out, USER_WIDTH: sideband of the same beat.
- `err_o`, out, 1: sticky self-check mismatch flag (see Configuration).

## Operation
- Stage 1 (S1): register x and p = x * M. p is 2*DATA_WIDTH+1 bits wide and is never truncated.
- Stage 2 (S2): q = p >> DATA_WIDTH, then r = x − q*MODULUS. r is held in R_WIDTH+1 bits and satisfies 0 ≤ r < 2*MODULUS. The estimate of q is short by at most 1.
- Stage 3 (S3): out = (r ≥ MODULUS) ? r − MODULUS : r. At most one correction is ever needed.
- Each stage has a valid bit. The user field and the stage data move with their valid bit.
- Global stall: `adv = !out_valid_o || out_ready_i`.
  - When adv=1, all stages shift one position. S1 loads the input when `in_valid_i && in_ready_o`, and loads a bubble otherwise.
  - When adv=0, all stage registers hold.
- `in_ready_o = adv`. This is combinational from `out_ready_i`. No combinational path exists from `in_valid_i` to `out_valid_o`.
- Bubbles propagate. Results leave in input order and none are dropped or duplicated.
- Power-of-two MODULUS needs no special case: M is exact, and r < MODULUS holds after S2.

## Timing
- Latency is 3 cycles. A beat accepted at edge N is presented at edge N+3 when there is no stall.
- Throughput is 1 beat per cycle while `out_ready_i` = 1.
- Reset (`rst_ni` = 0 at an edge) clears every stage valid bit and `err_o`. After that edge, `out_valid_o` = 0 and `out_data_o`/`out_user_o` = 0. While reset is asserted, `in_ready_o` = 1 (because `out_valid_o` = 0), but no beat is captured.
- Reset in mid-stream discards every in-flight beat. The first beat accepted after reset deasserts appears 3 cycles later.
- Handshake rules:
  - Once `out_valid_o` is asserted, `out_data_o` and `out_user_o` stay stable until `out_ready_i` is seen high.
  - The upstream side may drop `in_valid_i` at any time. The block does not require the source to hold its data.
- Simultaneous input accept and output drain in the same cycle at full occupancy is legal and sustains throughput.

## Configuration
- `MODULO_BARRETT_PIPE_CHECK_EN` defined: a shadow pipeline computes `x % MODULUS` with the native operator alongside the Barrett path. At S3, if the two results differ while the stage is valid and advancing, `err_o` sets and stays set until reset. A simulation `$error` fires at the same point.
- Not defined: no shadow logic is instantiated, and `err_o` is tied to 0.

## Test plan
- Reset and idle: hold `rst_ni` = 0 for 2 cycles with `in_valid_i` = 1, then release. `out_valid_o` = 0 for 3 cycles, and `err_o` = 0.
- Correction path (DATA_WIDTH = 8, MODULUS = 7, M = 36):
  - x = 255: S2 gives r = 10, output is 3.
  - x = 7: r = 7, output is 0.
  - x = 6: output is 6.
  - x = 0: output is 0.
  - Each result appears 3 cycles after acceptance, with the user tag matching.
- Streaming: drive x = 0..255 back-to-back with `out_ready_i` = 1. There are 256 outputs in order, one per cycle, each equal to x mod 7, and `err_o` stays 0.
- Backpressure: drive a random `out_ready_i` (50%) and a random `in_valid_i`. Check that no loss, no duplication and correct order hold, and that output data stays stable while stalled.
- Mid-stream reset: assert `rst_ni` = 0 with 3 beats in flight. No stale beat emerges afterwards, and a post-reset beat x = 100 yields 2 at +3 cycles.
- Sweep: DATA_WIDTH = 16 with MODULUS in {2, 3, 1000, 65535}, using corners 0, MODULUS−1, MODULUS, 2^16−1 plus 10k random values. All outputs must match the native `%` result.
